// File: rtl/mem_rr_arbiter.sv
// Round-robin memory bus arbiter for the weight, feature-map and output BIUs, with
// in-order response routing via a tag FIFO. Optional macro: ARB_BEAT_LIMIT_EN (per-grant beat cap).
module mem_rr_arbiter #(
   parameter int N_REQ     = 3,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int OST_DEPTH = 8,
   parameter int MAX_BEATS = 16,
   localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]    m_req,
   input  logic [N_REQ-1:0]    m_vld,
   input  logic [N_REQ*AW-1:0] m_addr,
   output logic [N_REQ-1:0]    m_rdy,
   output logic [AW-1:0]       s_addr,
   output logic [DW-1:0]       s_data,
   output logic [N_REQ-1:0]    s_vld,
   input  logic [N_REQ-1:0]    s_rdy,
   output logic [AW-1:0]       mem_req_addr,
   output logic                mem_req_vld,
   input  logic                mem_req_rdy,
   input  logic [AW-1:0]       mem_rsp_addr,
   input  logic [DW-1:0]       mem_rsp_data,
   input  logic                mem_rsp_vld,
   output logic                mem_rsp_rdy,
   output logic [IW-1:0]       gnt_id,
   output logic                gnt_act,
   output logic                rsp_err
);

   localparam int PW = $clog2(OST_DEPTH);

   if (N_REQ < 2 || N_REQ > 8 || OST_DEPTH < 2 || (OST_DEPTH & (OST_DEPTH - 1)) != 0 ||
       MAX_BEATS < 1) begin : g_bad_params
      $error("mem_rr_arbiter: illegal parameter set");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   cand;
   logic            found;
   logic [IW-1:0]   next_ptr;
   logic            release_grant;
   logic [AW-1:0]   addr_arr [N_REQ];

   logic [IW-1:0]   tag_mem [OST_DEPTH];
   logic [PW:0]     wr_ptr;
   logic [PW:0]     rd_ptr;
   logic            fifo_full;
   logic            fifo_empty;
   logic [IW-1:0]   head;
   logic            push;
   logic            pop;

   // First requester at or after rr_ptr, searching circularly.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IW'((int'(rr_ptr) + k) % N_REQ);
         if (!found && m_req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) addr_arr[i] = m_addr[i*AW +: AW];
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head       = tag_mem[rd_ptr[PW-1:0]];

   // Request path: owner's beats pass straight through, throttled only by tag space.
   assign mem_req_vld  = (state == GRANT) && m_vld[gnt_id] && !fifo_full;
   assign mem_req_addr = addr_arr[gnt_id];
   assign push         = mem_req_vld && mem_req_rdy;

   always_comb begin
      m_rdy = '0;
      if (state == GRANT && !fifo_full) m_rdy[gnt_id] = mem_req_rdy;
   end

   assign s_addr      = mem_rsp_addr;
   assign s_data      = mem_rsp_data;
   assign mem_rsp_rdy = !fifo_empty && s_rdy[head];
   assign pop         = mem_rsp_vld && mem_rsp_rdy;

   always_comb begin
      s_vld = '0;
      if (!fifo_empty) s_vld[head] = mem_rsp_vld;
   end

   assign next_ptr = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + IW'(1);

`ifdef ARB_BEAT_LIMIT_EN
   localparam int BW = $clog2(MAX_BEATS + 1);
   logic [BW-1:0] beat_cnt;
   // The beat that reaches the cap also ends the grant, so the next cycle is IDLE.
   assign release_grant = !m_req[gnt_id] || (push && beat_cnt == BW'(MAX_BEATS - 1));
`else
   assign release_grant = !m_req[gnt_id];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt_id  <= '0;
         gnt_act <= 1'b0;
         rr_ptr  <= '0;
`ifdef ARB_BEAT_LIMIT_EN
         beat_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|m_req) begin
                  gnt_id  <= sel;
                  gnt_act <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  gnt_act <= 1'b0;
                  rr_ptr  <= next_ptr;
                  state   <= IDLE;
`ifdef ARB_BEAT_LIMIT_EN
                  beat_cnt <= '0;
               end else if (push) begin
                  beat_cnt <= beat_cnt + BW'(1);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr[PW-1:0]] <= gnt_id;
   end

   // A response with no outstanding tag can never be routed; flag it until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          rsp_err <= 1'b0;
      else if (mem_rsp_vld && fifo_empty)  rsp_err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level model (owner, rotating pointer, tag queue)
// checked against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_mem_rr_arbiter;
   localparam int N    = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int OST  = 8;
   localparam int MAXB = 16;
   localparam int BIG  = 1 << 30;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]    m_req, m_vld, m_rdy, s_vld, s_rdy;
   logic [N*AW-1:0] m_addr;
   logic [AW-1:0]   s_addr, mem_req_addr, mem_rsp_addr;
   logic [DW-1:0]   s_data, mem_rsp_data;
   logic            mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
   logic [1:0]      gnt_id;
   logic            gnt_act, rsp_err;

   always #5 clk = ~clk;

   mem_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .OST_DEPTH(OST), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_vld(m_vld), .m_addr(m_addr), .m_rdy(m_rdy),
      .s_addr(s_addr), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
      .mem_req_addr(mem_req_addr), .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
      .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data), .mem_rsp_vld(mem_rsp_vld),
      .mem_rsp_rdy(mem_rsp_rdy),
      .gnt_id(gnt_id), .gnt_act(gnt_act), .rsp_err(rsp_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state
   bit          own_vld;
   int          owner, ptr, bcnt;
   int          tag_q[$];
   logic [31:0] mem_q[$];
   logic [31:0] exp_q[N][$];
   bit          err_m;

   // Stimulus state
   int          cnt_left[N];
   logic [31:0] base[N];
   int          idx[N];
   int          budget;
   bit          rdy_alt, srdy_alt, force_err, tog;

   // Observation logs
   int grant_log[$], grant_cyc[$], idle_log[$], beat_log[$], beat_cyc[$], rsp_log[$], rsp_cyc[$];
   int cycle = 0;
   int idle_run = 0;
   bit prev_act = 1'b0;

   function automatic logic [31:0] rsp_data_of(input logic [31:0] a);
      return ~a ^ 32'h5a5a_0000;
   endfunction

   function automatic int onehot_id(input logic [N-1:0] v);
      int id = -1;
      for (int i = 0; i < N; i++) if (v[i]) id = i;
      return id;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         m_req[i] = (cnt_left[i] > 0);
         m_vld[i] = (cnt_left[i] > 0);
         m_addr[i*AW +: AW] = base[i] + 32'(4 * idx[i]);
      end
      tog = ~tog;
      mem_req_rdy = rdy_alt ? tog : 1'b1;
      s_rdy = (srdy_alt && !tog) ? '0 : '1;
      if (force_err) begin
         mem_rsp_vld = 1'b1; mem_rsp_addr = 32'hdead_beef; mem_rsp_data = '0;
         force_err = 1'b0;
      end else if (budget > 0 && mem_q.size() > 0) begin
         mem_rsp_vld = 1'b1; mem_rsp_addr = mem_q[0]; mem_rsp_data = rsp_data_of(mem_q[0]);
      end else begin
         mem_rsp_vld = 1'b0; mem_rsp_addr = '0; mem_rsp_data = '0;
      end
   endtask

   // Model advance and input drive, 1 time unit after each active edge.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         own_vld = 0; ptr = 0; bcnt = 0; err_m = 0;
         tag_q.delete(); mem_q.delete();
         for (int i = 0; i < N; i++) begin exp_q[i].delete(); cnt_left[i] = 0; end
         drive_inputs();
      end else begin : adv
         bit acc, pop, pre_empty, rel;
         int hd;
         logic [31:0] a;
         pre_empty = (tag_q.size() == 0);
         acc = own_vld && m_vld[owner] && tag_q.size() < OST && mem_req_rdy;
         hd  = pre_empty ? 0 : tag_q[0];
         pop = mem_rsp_vld && !pre_empty && s_rdy[hd];
         if (mem_rsp_vld && pre_empty) err_m = 1;
         if (pop) begin
            void'(tag_q.pop_front()); void'(exp_q[hd].pop_front()); void'(mem_q.pop_front());
            if (budget > 0) budget--;
         end
         if (acc) begin
            a = base[owner] + 32'(4 * idx[owner]);
            tag_q.push_back(owner); mem_q.push_back(a); exp_q[owner].push_back(a);
            idx[owner]++; cnt_left[owner]--;
         end
         if (!own_vld) begin
            for (int k = N - 1; k >= 0; k--)
               if (m_req[(ptr + k) % N]) begin owner = (ptr + k) % N; own_vld = 1; end
            bcnt = 0;
         end else begin
            rel = !m_req[owner];
`ifdef ARB_BEAT_LIMIT_EN
            if (acc) bcnt++;
            if (bcnt == MAXB) rel = 1;
`endif
            if (rel) begin own_vld = 0; ptr = (owner + 1) % N; bcnt = 0; end
         end
         drive_inputs();
      end
   end

   // Compare process: DUT outputs against the model on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin : cmp
         bit full, empty, e_mvld;
         logic [N-1:0] e_mrdy, e_svld;
         full  = tag_q.size() >= OST;
         empty = tag_q.size() == 0;
         chk("gnt_act", gnt_act, own_vld);
         if (own_vld) chk("gnt_id", gnt_id, owner);
         e_mvld = own_vld && m_vld[owner] && !full;
         chk("mem_req_vld", mem_req_vld, e_mvld);
         if (e_mvld) chk("mem_req_addr", mem_req_addr, base[owner] + 32'(4 * idx[owner]));
         e_mrdy = '0;
         if (own_vld && !full && mem_req_rdy) e_mrdy[owner] = 1'b1;
         chk("m_rdy", m_rdy, e_mrdy);
         e_svld = '0;
         if (!empty && mem_rsp_vld) e_svld[tag_q[0]] = 1'b1;
         chk("s_vld", s_vld, e_svld);
         chk("mem_rsp_rdy", mem_rsp_rdy, !empty && s_rdy[empty ? 0 : tag_q[0]]);
         if (!empty && mem_rsp_vld) begin
            chk("s_addr", s_addr, exp_q[tag_q[0]][0]);
            chk("s_data", s_data, rsp_data_of(exp_q[tag_q[0]][0]));
         end
         chk("rsp_err", rsp_err, err_m);
         if (gnt_act && !prev_act) begin
            grant_log.push_back(gnt_id); grant_cyc.push_back(cycle); idle_log.push_back(idle_run);
         end
         idle_run = gnt_act ? 0 : idle_run + 1;
         prev_act = gnt_act;
         if (mem_req_vld && mem_req_rdy) begin beat_log.push_back(gnt_id); beat_cyc.push_back(cycle); end
         if (mem_rsp_vld && mem_rsp_rdy) begin rsp_log.push_back(onehot_id(s_vld)); rsp_cyc.push_back(cycle); end
      end
      cycle++;
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic clear_logs();
      grant_log.delete(); grant_cyc.delete(); idle_log.delete();
      beat_log.delete(); beat_cyc.delete(); rsp_log.delete(); rsp_cyc.delete();
   endtask

   function automatic bit cond(input int mode, input int n);
      bit quiet = !own_vld;
      for (int i = 0; i < N; i++) if (cnt_left[i] != 0) quiet = 0;
      case (mode)
         0: return quiet;
         1: return quiet && tag_q.size() == 0 && mem_q.size() == 0;
         default: return beat_log.size() >= n;
      endcase
   endfunction

   task automatic wait_for(input int mode, input int n, input int limit, input string name);
      int k = 0;
      while (!cond(mode, n) && k < limit) begin step(); k++; end
      chk({"timeout_", name}, cond(mode, n), 1);
   endtask

   int c0, n0;
   int exp_order[6] = '{1, 1, 1, 2, 2, 2};

   initial begin
      rst_n = 1'b0; m_req = '0; m_vld = '0; m_addr = '0; s_rdy = '1;
      mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0; mem_rsp_addr = '0; mem_rsp_data = '0;
      base[0] = 32'h1000; base[1] = 32'h2000; base[2] = 32'h3000;
      for (int i = 0; i < N; i++) begin cnt_left[i] = 0; idx[i] = 0; end
      budget = BIG; rdy_alt = 0; srdy_alt = 0; force_err = 0; tog = 0;
      repeat (3) @(posedge clk); #2;
      chk("rst_gnt_act", gnt_act, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_mem_req_vld", mem_req_vld, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_s_vld", s_vld, 0);
      chk("rst_mem_rsp_rdy", mem_rsp_rdy, 0);
      rst_n = 1'b1;
      step();

      // Three ports request together from rr_ptr=0
      clear_logs();
      for (int i = 0; i < N; i++) cnt_left[i] = 4;
      wait_for(1, 0, 200, "rr3");
      chk("rr3_grants", grant_log.size(), 3);
      if (grant_log.size() == 3) begin
         chk("rr3_order0", grant_log[0], 0);
         chk("rr3_order1", grant_log[1], 1);
         chk("rr3_order2", grant_log[2], 2);
         chk("rr3_gap1", idle_log[1], 1);
         chk("rr3_gap2", idle_log[2], 1);
      end
      clear_logs();
      for (int i = 0; i < N; i++) cnt_left[i] = 1;
      wait_for(1, 0, 100, "rr_wrap");
      chk("rr_wrap_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

      // Port 0 alone, 80 beats from 0x1000
      clear_logs();
      idx[0] = 0;
      c0 = cycle;
      cnt_left[0] = 80;
      wait_for(1, 0, 400, "long");
      chk("long_gnt_latency", (grant_cyc.size() > 0) ? grant_cyc[0] - c0 : -1, 2);
      chk("long_beats", beat_log.size(), 80);
      chk("long_rsps", rsp_log.size(), 80);
      n0 = 0;
      foreach (rsp_log[i]) if (rsp_log[i] == 0) n0++;
      chk("long_rsp_port0", n0, 80);
`ifndef ARB_BEAT_LIMIT_EN
      chk("long_grants", grant_log.size(), 1);
      if (beat_cyc.size() == 80) chk("long_back_to_back", beat_cyc[79] - beat_cyc[0], 79);
`endif

      // Tag FIFO fills with responses stalled
      clear_logs();
      budget = 0;
      cnt_left[0] = 9;
      repeat (20) step();
      chk("full_beats", beat_log.size(), 8);
      chk("full_m_rdy", m_rdy, 0);
      chk("full_mem_req_vld", mem_req_vld, 0);
      chk("full_gnt_act", gnt_act, 1);
      budget = 1;
      wait_for(2, 9, 50, "full_ninth");
      if (beat_cyc.size() == 9 && rsp_cyc.size() >= 1)
         chk("full_ninth_latency", beat_cyc[8] - rsp_cyc[0], 1);
      budget = BIG;
      wait_for(1, 0, 100, "full_drain");

      // Port 1 releases with responses pending, port 2 follows; stalls on both sides
      clear_logs();
      budget = 0; rdy_alt = 1;
      cnt_left[1] = 3; cnt_left[2] = 3;
      wait_for(0, 0, 100, "handoff_beats");
      chk("handoff_grants", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk("handoff_g0", grant_log[0], 1);
         chk("handoff_g1", grant_log[1], 2);
      end
      chk("handoff_pending", beat_log.size(), 6);
      budget = BIG; srdy_alt = 1;
      wait_for(1, 0, 100, "handoff_drain");
      rdy_alt = 0; srdy_alt = 0;
      chk("handoff_rsps", rsp_log.size(), 6);
      if (rsp_log.size() == 6) foreach (exp_order[i]) chk("handoff_route", rsp_log[i], exp_order[i]);

      // Response with empty FIFO, then reset mid-transfer
      clear_logs();
      force_err = 1;
      @(negedge clk); @(negedge clk); #1;
      chk("err_rsp_rdy", mem_rsp_rdy, 0);
      chk("err_not_yet", rsp_err, 0);
      @(negedge clk); #1;
      chk("err_set", rsp_err, 1);
      repeat (5) @(negedge clk);
      #1;
      chk("err_sticky", rsp_err, 1);
      step();
      budget = 0;
      cnt_left[2] = 5;
      wait_for(2, 3, 50, "rst_beats");
      rst_n = 1'b0;
      #1;
      chk("rst_mid_gnt_act", gnt_act, 0);
      chk("rst_mid_rsp_err", rsp_err, 0);
      chk("rst_mid_mem_req_vld", mem_req_vld, 0);
      chk("rst_mid_m_rdy", m_rdy, 0);
      budget = BIG;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      force_err = 1;
      repeat (3) step();
      chk("rst_flushed_err", rsp_err, 1);

`ifdef ARB_BEAT_LIMIT_EN
      // Beat cap: port 0 for 40 beats while port 1 waits
      clear_logs();
      idx[0] = 0;
      cnt_left[0] = 40; cnt_left[1] = 4;
      wait_for(1, 0, 300, "limit");
      chk("limit_beats", beat_log.size(), 44);
      if (beat_log.size() == 44) begin
         chk("limit_b16", beat_log[15], 0);
         chk("limit_b17", beat_log[16], 1);
         chk("limit_b20", beat_log[19], 1);
         chk("limit_b21", beat_log[20], 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
